// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, FSM state encoding and width helper for the
// FIR MAC sequencer. Optional build macro used by the design: FIR_FLUSH_EN.
package fir_pkg;

    // Tap count is fixed by the 3-bit coefficient memory address.
    localparam int NTAPS  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ACK  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } fir_state_e;

    // Full-precision accumulator width: 2W-bit products, 8 of them summed.
    function automatic int acc_width(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: NTAPS x W shift register holding x[n-k] in slot k.
// Build macro FIR_FLUSH_EN adds a synchronous clear that zeroes every slot.
module fir_delay_line #(
    parameter int W     = 8,
    parameter int NTAPS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift,
`ifdef FIR_FLUSH_EN
    input  logic               clear,
`endif
    input  logic [W-1:0]       din,
    output logic [NTAPS*W-1:0] slots
);

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_slot
            logic [W-1:0] slot_in;
            logic [W-1:0] slot_q;

            if (gi == 0) begin : g_head
                assign slot_in = din;
            end else begin : g_tail
                assign slot_in = slots[(gi-1)*W +: W];
            end

            // Each slot takes its upstream neighbour when a new sample shifts in.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
`ifdef FIR_FLUSH_EN
                end else if (clear) begin
                    slot_q <= '0;
`endif
                end else if (shift) begin
                    slot_q <= slot_in;
                end
            end

            assign slots[gi*W +: W] = slot_q;
        end
    endgenerate

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed 8-tap FIR controller. Walks the
// coefficient memory (registered read), multiply-accumulates against the
// delay line, presents y[n] on a valid/ready handshake and serialises
// coefficient reloads between sums.
// Build macro FIR_FLUSH_EN adds the `flush` input (delay-line clear in IDLE).
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = acc_width(W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     in_sample,
`ifdef FIR_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    coef_load_req,
    output logic                    coef_load_ack,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_write,
    input  logic signed [W-1:0]     mem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_LOAD = ST_LOAD;
    localparam logic [2:0] S_ACK  = ST_ACK;
    localparam logic [2:0] S_RUN  = ST_RUN;
    localparam logic [2:0] S_DONE = ST_DONE;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NTAPS - 1);

    // RUN-relative cycle numbers: 1 is the cycle after the accept edge.
    // Memory data for address k appears in cycle k+2, so taps fold in
    // during cycles 2..9 and the result is registered at the end of cycle 10.
    localparam logic [3:0] CNT_START     = 4'd1;
    localparam logic [3:0] CNT_FIRST_TAP = 4'd2;
    localparam logic [3:0] CNT_LAST_TAP  = 4'd9;
    localparam logic [3:0] CNT_OUT       = 4'd10;

    logic [2:0]              state_reg;
    logic                    alive_reg;
    logic [3:0]              run_cnt_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] out_data_reg;
    logic                    out_valid_reg;

    logic                    idle;
    logic                    flush_req;
    logic                    accept;
    logic [NTAPS*W-1:0]      slots_flat;
    logic signed [W-1:0]     slot_arr [NTAPS];
    logic [ADDR_W-1:0]       tap_idx;
    logic                    tap_active;
    logic signed [2*W-1:0]   product;
    logic signed [ACC_W-1:0] product_ext;

    assign idle = (state_reg == S_IDLE);

`ifdef FIR_FLUSH_EN
    // A reload request outranks flush; flush outranks a new sample.
    assign flush_req = idle && !coef_load_req && flush;
`else
    assign flush_req = 1'b0;
`endif

    // alive_reg keeps in_ready low until the first edge after reset release.
    assign in_ready = idle && alive_reg && !coef_load_req && !flush_req;
    assign accept   = in_valid && in_ready;

    fir_delay_line #(
        .W     (W),
        .NTAPS (NTAPS)
    ) u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (accept),
`ifdef FIR_FLUSH_EN
        .clear (flush_req),
`endif
        .din   (in_sample),
        .slots (slots_flat)
    );

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_unpack
            assign slot_arr[gi] = slots_flat[gi*W +: W];
        end
    endgenerate

    // Tap index is the RUN cycle number minus two, modulo 8.
    assign tap_idx     = run_cnt_reg[ADDR_W-1:0] - ADDR_W'(2);
    assign tap_active  = (state_reg == S_RUN) &&
                         (run_cnt_reg >= CNT_FIRST_TAP) &&
                         (run_cnt_reg <= CNT_LAST_TAP);
    assign product     = mem_rdata * slot_arr[tap_idx];
    assign product_ext = {{(ACC_W-2*W){product[2*W-1]}}, product};

    // Sequencer FSM with address walk, accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            alive_reg     <= 1'b0;
            run_cnt_reg   <= '0;
            addr_reg      <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            alive_reg <= 1'b1;
            case (state_reg)
                S_IDLE: begin
                    if (coef_load_req) begin
                        state_reg <= S_LOAD;
                    end else if (accept) begin
                        acc_reg     <= '0;
                        addr_reg    <= '0;
                        run_cnt_reg <= CNT_START;
                        state_reg   <= S_RUN;
                    end
                end
                S_LOAD: begin
                    state_reg <= S_ACK;
                end
                S_ACK: begin
                    state_reg <= S_IDLE;
                end
                S_RUN: begin
                    if (addr_reg != ADDR_LAST) begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                    if (tap_active) begin
                        acc_reg <= acc_reg + product_ext;
                    end
                    if (run_cnt_reg == CNT_OUT) begin
                        out_data_reg  <= acc_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end else begin
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr      = addr_reg;
    assign mem_write     = (state_reg == S_LOAD);
    assign coef_load_ack = (state_reg == S_ACK);
    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed plus randomized stimulus for the FIR MAC
// sequencer, checked every cycle against a timeline model of the filter
// (sample history, coefficient set, load and output windows).
// Built with FIR_FLUSH_EN undefined.
module tb_fir_mac_sequencer;

    localparam int W     = 8;
    localparam int ACC_W = 19;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [W-1:0]     in_sample = '0;
    logic                    coef_load_req = 1'b0;
    logic                    coef_load_ack;
    logic [2:0]              mem_addr;
    logic                    mem_write;
    logic signed [W-1:0]     mem_rdata = '0;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;

    logic dir_ready = 1'b1;
    logic rnd_ready = 1'b0;
    logic rand_bp   = 1'b0;
    assign out_ready = rand_bp ? rnd_ready : dir_ready;

    fir_mac_sequencer #(.W(W), .ACC_W(ACC_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sample     (in_sample),
        .coef_load_req (coef_load_req),
        .coef_load_ack (coef_load_ack),
        .mem_addr      (mem_addr),
        .mem_write     (mem_write),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));

    // Coefficient memory: bulk write on mem_write, registered read.
    logic signed [W-1:0] pend_coef [8];
    logic signed [W-1:0] cmem [8] = '{default: '0};
    always @(posedge clk) begin
        if (mem_write) begin
            for (int k = 0; k < 8; k++) cmem[k] <= pend_coef[k];
        end
        mem_rdata <= cmem[mem_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout, expected DUT event", name);
    endtask

    // ---------------- behavioural model ----------------
    longint hist [8]   = '{default: 0};
    longint m_coef [8] = '{default: 0};
    longint m_y = 0;
    bit     m_busy = 0, m_ov = 0, m_alive = 0, m_idle, exp_ready;
    int     m_lp = 0, m_due = 0, m_acc = 0, r;
    int     cyc = 0;
    int     last_ack_cyc = -1, last_acc_cyc = -1, last_wr_cyc = -1, last_hs_cyc = -1;
    longint got_q [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_ack", coef_load_ack, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            m_busy = 0; m_ov = 0; m_lp = 0; m_alive = 0;
            for (int k = 0; k < 8; k++) hist[k] = 0;
        end else begin
            if (m_busy && !m_ov && cyc == m_due) m_ov = 1;
            m_idle    = !m_busy && (m_lp == 0);
            exp_ready = m_idle && m_alive && !coef_load_req;
            chk("in_ready", in_ready, exp_ready);
            chk("mem_write", mem_write, m_lp == 1);
            chk("coef_load_ack", coef_load_ack, m_lp == 2);
            chk("out_valid", out_valid, m_ov);
            if (m_ov) chk("out_data", out_data, m_y);
            if (m_busy && !m_ov) begin
                r = cyc - m_acc;
                chk("mem_addr", mem_addr, (r - 1 > 7) ? 7 : r - 1);
            end
            if (mem_write) last_wr_cyc = cyc;
            if (coef_load_ack) last_ack_cyc = cyc;
            // what happens at the coming edge
            if (m_lp == 1) begin
                m_lp = 2;
                for (int k = 0; k < 8; k++) m_coef[k] = pend_coef[k];
            end else if (m_lp == 2) begin
                m_lp = 0;
            end else if (m_idle && coef_load_req) begin
                m_lp = 1;
            end else if (exp_ready && in_valid) begin
                for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = in_sample;
                m_y = 0;
                for (int k = 0; k < 8; k++) m_y += m_coef[k] * hist[k];
                m_busy = 1; m_acc = cyc; m_due = cyc + 11; last_acc_cyc = cyc;
            end
            if (m_ov && out_ready) begin
                got_q.push_back(out_data);
                $display("out #%0d: y=%0d at cycle %0d", got_q.size(), out_data, cyc);
                m_ov = 0; m_busy = 0; last_hs_cyc = cyc;
            end
            m_alive = 1;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic signed [W-1:0] s);
        bit ok = 0;
        in_sample = s;
        in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_sample = 8'($urandom);
        if (!ok) timeout_fail("send_accept");
    endtask

    task automatic do_load();
        bit ok = 0;
        coef_load_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (coef_load_ack) begin
                ok = 1;
                break;
            end
        end
        coef_load_req = 1'b0;
        if (!ok) timeout_fail("load_ack");
    endtask

    task automatic wait_outputs(input int n);
        for (int i = 0; i < 600; i++) begin
            if (got_q.size() >= n) break;
            @(posedge clk); #1;
        end
        if (got_q.size() < n) timeout_fail("wait_outputs");
    endtask

    initial begin
        int n_sent;
        bit hit;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid      = 1'($urandom_range(0, 1));
            coef_load_req = 1'($urandom_range(0, 1));
            in_sample     = 8'($urandom);
            dir_ready     = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0; coef_load_req = 1'b0; dir_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", in_ready, 1);

        // Impulse response with c = 1..8.
        for (int k = 0; k < 8; k++) pend_coef[k] = 8'(k + 1);
        do_load();
        got_q.delete();
        send(8'sd1);
        for (int i = 0; i < 7; i++) send(8'sd0);
        wait_outputs(8);
        for (int k = 0; k < 8 && k < got_q.size(); k++) chk("impulse", got_q[k], k + 1);

        // Reset in the middle of a sum.
        send(8'sd1);
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mem_addr == 3'd4) begin
                hit = 1;
                break;
            end
        end
        if (!hit) timeout_fail("mid_run_addr4");
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        got_q.delete();
        send(8'sd1);
        wait_outputs(1);
        if (got_q.size() > 0) chk("reset_keeps_c0", got_q[0], 1);

        // Signed: all coefficients -1, eight samples of 127.
        for (int k = 0; k < 8; k++) pend_coef[k] = -8'sd1;
        do_load();
        got_q.delete();
        for (int i = 0; i < 8; i++) send(8'sd127);
        wait_outputs(8);
        if (got_q.size() >= 8) chk("signed_eighth", got_q[7], -1016);

        // Backpressure for five cycles in DONE.
        dir_ready = 1'b0;
        got_q.delete();
        send(8'sd3);
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                hit = 1;
                break;
            end
        end
        if (!hit) timeout_fail("bp_out_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", out_valid, 1);
            chk("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        dir_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", out_valid, 0);
        if (got_q.size() > 0) chk("bp_data", got_q[0], -892);

        // Request and sample raised together in IDLE: load goes first.
        for (int k = 0; k < 8; k++) pend_coef[k] = 8'(k + 1);
        got_q.delete();
        in_sample = 8'sd5;
        in_valid  = 1'b1;
        do_load();
        send(8'sd5);
        wait_outputs(1);
        chk("arb_load_first", longint'(last_acc_cyc > last_ack_cyc), 1);
        if (got_q.size() > 0) chk("arb_data", got_q[0], 4202);

        // Request raised during RUN waits until the sum is delivered.
        got_q.delete();
        send(8'sd7);
        for (int k = 0; k < 8; k++) pend_coef[k] = 8'sd2;
        do_load();
        chk("run_req_deferred", longint'(last_wr_cyc > last_hs_cyc), 1);
        chk("run_req_one_output", got_q.size(), 1);
        if (got_q.size() > 0) chk("run_req_data", got_q[0], 3836);

        // Randomized traffic with random backpressure and reloads.
        rand_bp = 1'b1;
        got_q.delete();
        n_sent = 0;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    for (int k = 0; k < 8; k++) pend_coef[k] = 8'($urandom);
                    do_load();
                end
                1: repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                    in_sample = 8'($urandom);
                end
                default: begin
                    send(8'($urandom));
                    n_sent++;
                end
            endcase
        end
        wait_outputs(n_sent);
        chk("random_count", got_q.size(), n_sent);
        rand_bp = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
